// File: rtl/hms_time_counter_pkg.sv
// Shared definitions for the hours/minutes/seconds time-of-day counter.
//   mode_e         : mode FSM encoding, also the value driven on the mode output
//   *_MAX_BCD      : last legal packed-BCD value of the seconds/minutes fields
//   to_bcd         : converts a small integer (0..99) to packed {tens,ones} BCD
//   hr_mod_legal   : true for the supported hour moduli (12 and 24)
//   hr_max_bcd     : last legal hour value as packed BCD for a given modulus
package hms_time_counter_pkg;

    typedef enum logic [1:0] {
        MODE_RUN     = 2'b00,
        MODE_SET_HR  = 2'b01,
        MODE_SET_MIN = 2'b10,
        MODE_ILLEGAL = 2'b11
    } mode_e;

    localparam logic [7:0] SEC_MAX_BCD = 8'h59;
    localparam logic [7:0] MIN_MAX_BCD = 8'h59;

    function automatic logic [7:0] to_bcd(input int unsigned v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic bit hr_mod_legal(input int unsigned m);
        return (m == 12) || (m == 24);
    endfunction

    function automatic logic [7:0] hr_max_bcd(input int unsigned m);
        return to_bcd(m - 1);
    endfunction

endpackage

// File: rtl/hms_time_counter_if.sv
// Signal bundle between the tick generator / button front end and the
// time counter, plus the counter's display-side outputs.
//   tick       : one-cycle 1 Hz pulse
//   mode_btn   : debounced level, rising edge advances the mode FSM
//   inc_btn    : debounced level, rising edge increments the selected field
//   sec_bcd    : seconds, packed BCD 00..59
//   min_bcd    : minutes, packed BCD 00..59
//   hr_bcd     : hours, packed BCD 00..HR_MOD-1
//   mode       : 00 RUN, 01 SET_HR, 10 SET_MIN
//   day_pulse  : one-cycle pulse on the last-second-of-day rollover
// master drives the inputs and observes the outputs; slave is the counter.
interface hms_time_counter_if;
    logic       tick;
    logic       mode_btn;
    logic       inc_btn;
    logic [7:0] sec_bcd;
    logic [7:0] min_bcd;
    logic [7:0] hr_bcd;
    logic [1:0] mode;
    logic       day_pulse;

    modport master (
        output tick, mode_btn, inc_btn,
        input  sec_bcd, min_bcd, hr_bcd, mode, day_pulse
    );

    modport slave (
        input  tick, mode_btn, inc_btn,
        output sec_bcd, min_bcd, hr_bcd, mode, day_pulse
    );
endinterface

// File: rtl/hms_time_counter_bcd_mod_counter.sv
// Two-digit packed-BCD counter that wraps after MAX_BCD.
//   clk, reset : clock and synchronous active-high reset (value -> 00)
//   inc        : advance by one this cycle
//   clr        : load 00 this cycle (wins over inc)
//   value      : registered {tens,ones} BCD value
//   wrap       : combinational, high when inc is asserted while value == MAX_BCD
module bcd_mod_counter #(
    parameter logic [7:0] MAX_BCD = 8'h59
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       inc,
    input  logic       clr,
    output logic [7:0] value,
    output logic       wrap
);

    logic [7:0] value_d;

    assign wrap = inc && (value == MAX_BCD);

    always_comb begin
        value_d = value;
        if (clr) begin
            value_d = 8'h00;
        end else if (inc) begin
            // The packed compare is numeric for legal digits; any corrupt value
            // (ones digit > 9, or beyond the modulus) also lands here and recovers to 00.
            if ((value[3:0] > 4'd9) || (value >= MAX_BCD)) begin
                value_d = 8'h00;
            end else if (value[3:0] == 4'd9) begin
                value_d = {value[7:4] + 4'd1, 4'd0};
            end else begin
                value_d = {value[7:4], value[3:0] + 4'd1};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            value <= 8'h00;
        end else begin
            value <= value_d;
        end
    end

endmodule

// File: rtl/hms_time_counter.sv
// Time-of-day counter: seconds/minutes/hours in packed BCD advanced by the
// 1 Hz tick, with a RUN / SET_HR / SET_MIN mode FSM driven by two buttons.
//   clk    : system clock
//   reset  : synchronous, active-high
//   bus    : hms_time_counter_if.slave (tick, buttons in; BCD fields, mode,
//            day_pulse out)
// Priority in one cycle is mode edge > inc edge > tick; whichever loses is
// dropped, not deferred.
module hms_time_counter
    import hms_time_counter_pkg::*;
#(
    parameter int unsigned HR_MOD = 24
) (
    input  logic                  clk,
    input  logic                  reset,
    hms_time_counter_if.slave     bus
);

    if (!hr_mod_legal(HR_MOD)) begin : g_hr_mod_check
        $error("hms_time_counter: HR_MOD must be 12 or 24");
    end

    localparam logic [7:0] HR_MAX_BCD = hr_max_bcd(HR_MOD);

    // Button history starts at 1 so a button already held when reset is
    // released does not register as a press.
    logic mode_btn_q;
    logic inc_btn_q;
    logic mode_edge;
    logic inc_edge;

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_btn_q <= 1'b1;
            inc_btn_q  <= 1'b1;
        end else begin
            mode_btn_q <= bus.mode_btn;
            inc_btn_q  <= bus.inc_btn;
        end
    end

    assign mode_edge = bus.mode_btn & ~mode_btn_q;
    assign inc_edge  = bus.inc_btn  & ~inc_btn_q;

    // Mode FSM: the registered state is the mode output.
    mode_e state_q;
    mode_e state_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= MODE_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    logic sec_inc;
    logic sec_clr;
    logic min_inc;
    logic hr_inc;
    logic sec_wrap;
    logic min_wrap;
    logic hr_wrap;
    logic day_pulse_d;

    always_comb begin
        state_d     = state_q;
        sec_inc     = 1'b0;
        sec_clr     = 1'b0;
        min_inc     = 1'b0;
        hr_inc      = 1'b0;
        day_pulse_d = 1'b0;
        case (state_q)
            MODE_RUN: begin
                if (mode_edge) begin
                    state_d = MODE_SET_HR;
                    sec_clr = 1'b1;
                end else begin
                    sec_inc = bus.tick;
                end
                // Carry chain; the wrap flags are already gated by each stage's inc.
                min_inc     = sec_wrap;
                hr_inc      = min_wrap;
                day_pulse_d = hr_wrap;
            end
            MODE_SET_HR: begin
                if (mode_edge) begin
                    state_d = MODE_SET_MIN;
                end else begin
                    hr_inc = inc_edge;
                end
            end
            MODE_SET_MIN: begin
                if (mode_edge) begin
                    state_d = MODE_RUN;
                end else begin
                    min_inc = inc_edge;
                end
            end
            default: begin
                state_d = MODE_RUN;
            end
        endcase
    end

    logic [7:0] sec_val;
    logic [7:0] min_val;
    logic [7:0] hr_val;

    bcd_mod_counter #(.MAX_BCD(SEC_MAX_BCD)) u_sec (
        .clk   (clk),
        .reset (reset),
        .inc   (sec_inc),
        .clr   (sec_clr),
        .value (sec_val),
        .wrap  (sec_wrap)
    );

    bcd_mod_counter #(.MAX_BCD(MIN_MAX_BCD)) u_min (
        .clk   (clk),
        .reset (reset),
        .inc   (min_inc),
        .clr   (1'b0),
        .value (min_val),
        .wrap  (min_wrap)
    );

    bcd_mod_counter #(.MAX_BCD(HR_MAX_BCD)) u_hr (
        .clk   (clk),
        .reset (reset),
        .inc   (hr_inc),
        .clr   (1'b0),
        .value (hr_val),
        .wrap  (hr_wrap)
    );

    logic day_pulse_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            day_pulse_q <= 1'b0;
        end else begin
            day_pulse_q <= day_pulse_d;
        end
    end

    assign bus.sec_bcd   = sec_val;
    assign bus.min_bcd   = min_val;
    assign bus.hr_bcd    = hr_val;
    assign bus.mode      = state_q;
    assign bus.day_pulse = day_pulse_q;

endmodule

// File: tb/tb_hms_time_counter.sv
// Directed bench for hms_time_counter: a 24-hour instance carries most of the
// sequence, a 12-hour instance checks the 11:59:59 rollover.
module tb_hms_time_counter;

    logic clk;
    logic reset;

    hms_time_counter_if if24 ();
    hms_time_counter_if if12 ();

    hms_time_counter #(.HR_MOD(24)) dut24 (
        .clk   (clk),
        .reset (reset),
        .bus   (if24.slave)
    );

    hms_time_counter #(.HR_MOD(12)) dut12 (
        .clk   (clk),
        .reset (reset),
        .bus   (if12.slave)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [23:0] exp_q[$];
    int dp24_cnt = 0;
    int dp12_cnt = 0;

    // day_pulse occurrences, sampled on the inactive edge
    always @(negedge clk) begin
        if (if24.day_pulse === 1'b1) dp24_cnt++;
        if (if12.day_pulse === 1'b1) dp12_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_time(input int sel, input string tag,
                              input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        logic [23:0] obs;
        logic [23:0] exp;
        exp_q.push_back({h, m, s});
        obs = (sel == 0) ? {if24.hr_bcd, if24.min_bcd, if24.sec_bcd}
                         : {if12.hr_bcd, if12.min_bcd, if12.sec_bcd};
        exp = exp_q.pop_front();
        check_eq(tag, {8'h00, obs}, {8'h00, exp});
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_tick(input int sel, input logic v);
        if (sel == 0) if24.tick = v; else if12.tick = v;
    endtask

    task automatic set_mode_btn(input int sel, input logic v);
        if (sel == 0) if24.mode_btn = v; else if12.mode_btn = v;
    endtask

    task automatic set_inc_btn(input int sel, input logic v);
        if (sel == 0) if24.inc_btn = v; else if12.inc_btn = v;
    endtask

    task automatic ticks(input int sel, input int n);
        for (int i = 0; i < n; i++) begin
            set_tick(sel, 1'b1);
            step();
            set_tick(sel, 1'b0);
        end
    endtask

    task automatic press_mode(input int sel);
        set_mode_btn(sel, 1'b1);
        step();
        set_mode_btn(sel, 1'b0);
        step();
    endtask

    task automatic press_inc(input int sel, input int n);
        for (int i = 0; i < n; i++) begin
            set_inc_btn(sel, 1'b1);
            step();
            set_inc_btn(sel, 1'b0);
            step();
        end
    endtask

    // ---------------- sequence ----------------
    initial begin
        reset = 1'b1;
        if24.tick = 1'b0; if24.mode_btn = 1'b0; if24.inc_btn = 1'b0;
        if12.tick = 1'b0; if12.mode_btn = 1'b0; if12.inc_btn = 1'b0;

        // 1. reset
        step();
        step();
        reset = 1'b0;
        step();
        check_time(0, "reset_time", 8'h00, 8'h00, 8'h00);
        check_eq("reset_mode", {30'd0, if24.mode}, 32'd0);
        check_eq("reset_day_pulse", {31'd0, if24.day_pulse}, 32'd0);

        // 2. seconds carry into minutes
        ticks(0, 58);
        check_time(0, "sec_58", 8'h00, 8'h00, 8'h58);
        ticks(0, 1);
        check_time(0, "sec_59", 8'h00, 8'h00, 8'h59);
        ticks(0, 1);
        check_time(0, "min_carry", 8'h00, 8'h01, 8'h00);
        check_eq("no_day_pulse_early", dp24_cnt, 0);

        // 3. day rollover at 23:59:59
        press_mode(0);
        press_inc(0, 23);
        press_mode(0);
        press_inc(0, 58);
        press_mode(0);
        ticks(0, 59);
        check_time(0, "pre_rollover_24", 8'h23, 8'h59, 8'h59);
        ticks(0, 1);
        check_time(0, "rollover_24", 8'h00, 8'h00, 8'h00);
        check_eq("day_pulse_high_24", {31'd0, if24.day_pulse}, 32'd1);
        step();
        check_eq("day_pulse_low_24", {31'd0, if24.day_pulse}, 32'd0);
        check_eq("day_pulse_count_24", dp24_cnt, 1);

        // 4. setting hours and minutes from 10:20:33
        press_mode(0);
        press_inc(0, 10);
        press_mode(0);
        press_inc(0, 20);
        press_mode(0);
        ticks(0, 33);
        check_time(0, "run_10_20_33", 8'h10, 8'h20, 8'h33);
        press_mode(0);
        check_eq("mode_set_hr", {30'd0, if24.mode}, 32'd1);
        check_time(0, "enter_set_hr", 8'h10, 8'h20, 8'h00);
        press_inc(0, 15);
        ticks(0, 3);
        check_time(0, "set_hr_wrap", 8'h01, 8'h20, 8'h00);
        press_mode(0);
        check_eq("mode_set_min", {30'd0, if24.mode}, 32'd2);
        press_inc(0, 45);
        ticks(0, 3);
        check_time(0, "set_min_wrap", 8'h01, 8'h05, 8'h00);
        press_mode(0);
        check_eq("mode_back_run", {30'd0, if24.mode}, 32'd0);
        check_eq("no_day_pulse_in_set", dp24_cnt, 1);

        // 5. mode edge beats tick; held inc counts once
        ticks(0, 3);
        check_time(0, "run_01_05_03", 8'h01, 8'h05, 8'h03);
        if24.tick = 1'b1;
        if24.mode_btn = 1'b1;
        step();
        if24.tick = 1'b0;
        check_eq("mode_over_tick", {30'd0, if24.mode}, 32'd1);
        check_time(0, "mode_over_tick_time", 8'h01, 8'h05, 8'h00);
        if24.mode_btn = 1'b0;
        step();
        if24.inc_btn = 1'b1;
        repeat (100) step();
        if24.inc_btn = 1'b0;
        step();
        check_time(0, "held_inc_once", 8'h02, 8'h05, 8'h00);

        // 6. reset from SET_MIN at 07:41:00 with mode_btn held across release
        press_inc(0, 5);
        press_mode(0);
        press_inc(0, 36);
        check_time(0, "set_min_07_41", 8'h07, 8'h41, 8'h00);
        check_eq("mode_before_reset", {30'd0, if24.mode}, 32'd2);
        reset = 1'b1;
        if24.mode_btn = 1'b1;
        step();
        check_time(0, "reset_mid_op", 8'h00, 8'h00, 8'h00);
        check_eq("reset_mid_op_mode", {30'd0, if24.mode}, 32'd0);
        reset = 1'b0;
        step();
        step();
        check_eq("held_btn_no_edge", {30'd0, if24.mode}, 32'd0);
        if24.mode_btn = 1'b0;
        step();
        press_mode(0);
        check_eq("edge_after_release", {30'd0, if24.mode}, 32'd1);

        // 12-hour instance: 11:59:59 -> 00:00:00
        press_mode(1);
        press_inc(1, 11);
        press_mode(1);
        press_inc(1, 59);
        press_mode(1);
        ticks(1, 59);
        check_time(1, "pre_rollover_12", 8'h11, 8'h59, 8'h59);
        ticks(1, 1);
        check_time(1, "rollover_12", 8'h00, 8'h00, 8'h00);
        check_eq("day_pulse_high_12", {31'd0, if12.day_pulse}, 32'd1);
        step();
        check_eq("day_pulse_low_12", {31'd0, if12.day_pulse}, 32'd0);
        check_eq("day_pulse_count_12", dp12_cnt, 1);

        // ---------------- report ----------------
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
